x_ram_dp_init: RTL
==================

# x_ram_dp_init

Parametrised dual-port distributed RAM, the successor to the 16x1 single-port primitive. It has a configurable word width and depth, and a synchronous write port with its own read-back output. A second, independent read-only port is added, with an optional output register. A built-in fill engine writes a known word to every location after reset or on demand. It sits in the simulation primitive library as the building block for register files and small FIFOs.

## Interface
- `WIDTH`, 1: data word width in bits, 1..64.
- `ADDR_W`, 4: address width; DEPTH = 2**ADDR_W, ADDR_W 1..8.
- `INIT`, {WIDTH{1'b0}}: word written to every location by the fill engine.
- `OUT_REG`, 0: 0 = asynchronous reads; 1 = registered reads, 1-cycle latency.

- `CLK` input 1: clock; all writes and registers on the rising edge.
- `RSTN` input 1: asynchronous active-low reset.
- `CLR` input 1: synchronous request to re-run the fill; single-cycle pulse.
- `WE` input 1: write enable for port A.
- `WADR` input ADDR_W: port A address, used for both write and read-back.
- `I` input WIDTH: write data.
- `RADR` input ADDR_W: port B read address.
- `SPO` output WIDTH: port A read data, mem[WADR].
- `DPO` output WIDTH: port B read data, mem[RADR].
- `READY` output 1: high once the fill is complete and the RAM accepts writes.

## Operation
- Fill engine FSM has two states: FILL and IDLE.
- Reset (RSTN low):
  - state = FILL, fill counter = 0, READY = 0.
  - Output registers (OUT_REG=1) = 0.
  - Memory array contents are not reset.
- FILL: on each CLK edge, write mem[cnt] = INIT and increment cnt.
  - The edge that writes DEPTH-1 moves the FSM to IDLE and sets READY = 1.
  - cnt wraps to 0.
- IDLE: a CLK edge with WE=1 writes mem[WADR] = I.
- CLR=1 in IDLE: next edge enters FILL with cnt = 0 and READY = 0. No user write occurs on that edge, even if WE=1.
- CLR=1 during FILL: counter restarts at 0. Locations already filled are rewritten.
- WE during FILL (READY=0): ignored; no write, no error.
- While READY=0, SPO and DPO are driven to 0 in both OUT_REG modes.
- WADR == RADR with a simultaneous write:
  - OUT_REG=0: both outputs show the new data after the write edge.
  - OUT_REG=1: read-first; the outputs register the old data on the write edge, and the new data appears one edge later.
- Address width is exact; no out-of-range case exists.

## Timing
- Fill duration: READY rises on the DEPTH-th rising edge after RSTN deasserts. With ADDR_W=4 that is the 16th edge.
- Write: one cycle; the data is in the array after the edge with WE && READY.
- OUT_REG=0 read: combinational from the address and array contents; zero cycles.
- OUT_REG=1 read: SPO/DPO update on the edge after the address is presented. The first valid registered value is the edge after READY rises.
- RSTN assertion takes effect immediately, mid-fill or mid-write. A write on the same edge as RSTN assertion is not guaranteed.
- READY is registered and glitch-free.

## Structure
- Package `x_ram_pkg`:
  - fill FSM state enum (FILL, IDLE)
  - constants for the legal WIDTH and ADDR_W ranges
  - elaboration-time parameter check that issues $error when a parameter is out of range
- Sub-module `x_ram_fill_ctrl`:
  - contains the FSM, the ADDR_W-bit counter and READY
  - outputs the fill write-enable and fill address, which the top muxes against WE/WADR/I
- Top level holds the array, the write mux, the two read muxes, and the optional output registers under a generate on OUT_REG.

## Test plan
- Reset/fill: WIDTH=8, ADDR_W=4, INIT=8'hA5; release RSTN, hold WE=1, I=8'hFF → READY=0 for 15 edges and 1 after the 16th edge; all 16 locations read 8'hA5.
- Basic dual-port access, OUT_REG=0: write 8'h3C at 4'h7 and 8'hC3 at 4'h8 → WADR=4'h7 gives SPO=8'h3C while RADR=4'h8 gives DPO=8'hC3, both combinational.
- Read-during-write, OUT_REG=1: location 4'h2=8'h11, write 8'h22 at 4'h2 with RADR=4'h2 → DPO=8'h11 after the write edge, 8'h22 one edge later.
- CLR mid-operation: in IDLE write 8'h5A at 4'hF, pulse CLR together with WE=1 → no user write; READY low for 16 edges; mem[4'hF]=8'hA5 afterwards.
- Reset mid-fill: assert RSTN low after 9 fill edges, release → READY needs a full 16 edges; outputs are 0 throughout; all locations end at INIT.
- Writes blocked during fill: during FILL drive WE=1, WADR=4'h0, I=8'h77 every cycle → mem[4'h0]=8'hA5 after READY.

Source files
------------

// File: rtl/x_ram_dp_init_pkg.sv
// Shared types and parameter limits for the dual-port distributed RAM with fill engine.
package x_ram_pkg;

  // Fill engine states: FILL writes INIT across the array, IDLE serves user writes.
  typedef enum logic {
    FILL = 1'b0,
    IDLE = 1'b1
  } fill_state_t;

  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;
  localparam int ADDR_W_MIN = 1;
  localparam int ADDR_W_MAX = 8;

  // True when both geometry parameters are inside the supported ranges.
  function automatic bit params_ok(input int width, input int addr_w);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (addr_w >= ADDR_W_MIN) && (addr_w <= ADDR_W_MAX);
  endfunction

endpackage

// File: rtl/x_ram_dp_init_if.sv
// Bus bundle for the RAM: port A write/read-back, port B read, fill control and status.
interface x_ram_dp_init_if #(
  parameter int WIDTH  = 1,
  parameter int ADDR_W = 4
);
  logic              CLR;
  logic              WE;
  logic [ADDR_W-1:0] WADR;
  logic [WIDTH-1:0]  I;
  logic [ADDR_W-1:0] RADR;
  logic [WIDTH-1:0]  SPO;
  logic [WIDTH-1:0]  DPO;
  logic              READY;

  modport master (
    output CLR, WE, WADR, I, RADR,
    input  SPO, DPO, READY
  );

  modport slave (
    input  CLR, WE, WADR, I, RADR,
    output SPO, DPO, READY
  );
endinterface

// File: rtl/x_ram_dp_init_fill_ctrl.sv
// Fill engine: walks every address once after reset or CLR, then raises READY.
module x_ram_fill_ctrl
  import x_ram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CLR,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              ready
);

  fill_state_t       state;
  fill_state_t       state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;
  logic              ready_next;

  // State, fill counter and READY registers; reset restarts the fill from address 0.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= FILL;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= ready_next;
    end
  end

  // Next-state logic: CLR always restarts at 0; the write to the last address ends the fill.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready_next = ready;
    unique case (state)
      FILL: begin
        if (CLR) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt + 1'b1;
          if (cnt == '1) begin
            state_next = IDLE;
            ready_next = 1'b1;
          end
        end
      end
      IDLE: begin
        if (CLR) begin
          state_next = FILL;
          cnt_next   = '0;
          ready_next = 1'b0;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Hold off array writes while reset is asserted so memory contents are left untouched.
  assign fill_we   = (state == FILL) && RSTN;
  assign fill_addr = cnt;

endmodule

// File: rtl/x_ram_dp_init.sv
// Parametrised dual-port distributed RAM with a built-in INIT fill engine.
module x_ram_dp_init
  import x_ram_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               ADDR_W  = 4,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter bit               OUT_REG = 1'b0
) (
  input logic             CLK,
  input logic             RSTN,
  x_ram_dp_init_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  if (!params_ok(WIDTH, ADDR_W)) begin : g_param_err
    $error("x_ram_dp_init: WIDTH=%0d or ADDR_W=%0d out of range", WIDTH, ADDR_W);
  end

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic              ready;
  logic              user_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  spo_raw;
  logic [WIDTH-1:0]  dpo_raw;

  x_ram_fill_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_fill (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .CLR       (bus.CLR),
    .fill_we   (fill_we),
    .fill_addr (fill_addr),
    .ready     (ready)
  );

  // User writes only land once the fill is done, and a CLR edge swallows them.
  assign user_we = bus.WE && ready && !bus.CLR;
  assign wr_en   = fill_we || user_we;
  assign wr_addr = fill_we ? fill_addr : bus.WADR;
  assign wr_data = fill_we ? INIT : bus.I;

  // Single write port shared between the fill engine and port A.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign spo_raw = mem[bus.WADR];
  assign dpo_raw = mem[bus.RADR];

  if (OUT_REG) begin : g_out_reg
    logic [WIDTH-1:0] spo_q;
    logic [WIDTH-1:0] dpo_q;

    // Read-first output registers: they sample the array before a same-edge write lands.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        spo_q <= '0;
        dpo_q <= '0;
      end else begin
        spo_q <= ready ? spo_raw : '0;
        dpo_q <= ready ? dpo_raw : '0;
      end
    end

    // Gate again so the outputs drop the same edge READY falls after a CLR.
    assign bus.SPO = ready ? spo_q : '0;
    assign bus.DPO = ready ? dpo_q : '0;
  end else begin : g_out_comb
    assign bus.SPO = ready ? spo_raw : '0;
    assign bus.DPO = ready ? dpo_raw : '0;
  end

  assign bus.READY = ready;

endmodule
